// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - instruction, ALU-control and memory-request bundle of control_sequencer
// ILLEGAL exists only when ILLEGAL_OP_TRAP_EN is defined.
interface control_sequencer_if #(
    parameter int REG_ADDR_W = 3
);
    logic [31:0]           INSTRUCTION;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic                  ZERO;
    logic                  MEM_BUSYWAIT;
    logic [2:0]            ALU_OP;
    logic                  NEG_SEL;
    logic                  IMM_SEL;
    logic [7:0]            IMM;
    logic [REG_ADDR_W-1:0] READREG1;
    logic [REG_ADDR_W-1:0] READREG2;
    logic [REG_ADDR_W-1:0] WRITEREG;
    logic                  WRITEENABLE;
    logic                  MEM_READ;
    logic                  MEM_WRITE;
    logic [7:0]            OFFSET;
    logic                  PC_EN;
    logic                  PC_BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
    logic                  ILLEGAL;
`endif

    modport master (
        output INSTRUCTION, INSTR_VALID, ZERO, MEM_BUSYWAIT,
        input  INSTR_READY, ALU_OP, NEG_SEL, IMM_SEL, IMM, READREG1, READREG2,
        input  WRITEREG, WRITEENABLE, MEM_READ, MEM_WRITE, OFFSET, PC_EN, PC_BRANCH
`ifdef ILLEGAL_OP_TRAP_EN
        , input ILLEGAL
`endif
    );

    modport slave (
        input  INSTRUCTION, INSTR_VALID, ZERO, MEM_BUSYWAIT,
        output INSTR_READY, ALU_OP, NEG_SEL, IMM_SEL, IMM, READREG1, READREG2,
        output WRITEREG, WRITEENABLE, MEM_READ, MEM_WRITE, OFFSET, PC_EN, PC_BRANCH
`ifdef ILLEGAL_OP_TRAP_EN
        , output ILLEGAL
`endif
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle decode/execute/memory/retire sequencer feeding the ALU
// Optional ILLEGAL_OP_TRAP_EN: illegal opcodes lock the sequencer in TRAP until reset.
module control_sequencer #(
    parameter int OPCODE_W   = 8,
    parameter int REG_ADDR_W = 3
) (
    input logic                CLK,
    input logic                RESET,
    control_sequencer_if.slave bus
);
    localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_LWD   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_LWI   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_SWD   = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_SWI   = OPCODE_W'(11);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_RETIRE = 3'd4
`ifdef ILLEGAL_OP_TRAP_EN
        , S_TRAP = 3'd5
`endif
    } state_t;

    state_t state, state_nxt;

    logic [31:0]           instr_q;
    logic [OPCODE_W-1:0]   opcode;
    logic [2:0]            alu_op_q;
    logic                  neg_q, imm_sel_q, we_q, rd_q, wr_q, jump_q, beq_q, mem_q, taken_q;
    logic [7:0]            imm_q, offset_q;
    logic [REG_ADDR_W-1:0] rr1_q, rr2_q, wreg_q;

    logic [2:0] d_alu_op;
    logic       d_neg, d_imm_sel, d_we, d_rd, d_wr, d_jump, d_beq, d_illegal;

    assign opcode = instr_q[31 -: OPCODE_W];

    always_comb begin
        d_alu_op  = 3'b000;
        d_neg     = 1'b0;
        d_imm_sel = 1'b0;
        d_we      = 1'b0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_jump    = 1'b0;
        d_beq     = 1'b0;
        d_illegal = 1'b0;
        case (opcode)
            OP_LOADI: begin d_imm_sel = 1'b1; d_we = 1'b1; end
            OP_MOV:   d_we = 1'b1;
            OP_ADD:   begin d_alu_op = 3'b001; d_we = 1'b1; end
            OP_SUB:   begin d_alu_op = 3'b001; d_neg = 1'b1; d_we = 1'b1; end
            OP_AND:   begin d_alu_op = 3'b010; d_we = 1'b1; end
            OP_OR:    begin d_alu_op = 3'b011; d_we = 1'b1; end
            OP_J:     begin d_alu_op = 3'b100; d_jump = 1'b1; end
            OP_BEQ:   begin d_alu_op = 3'b101; d_neg = 1'b1; d_beq = 1'b1; end
            OP_LWD:   begin d_rd = 1'b1; d_we = 1'b1; end
            OP_LWI:   begin d_rd = 1'b1; d_we = 1'b1; d_imm_sel = 1'b1; end
            OP_SWD:   d_wr = 1'b1;
            OP_SWI:   begin d_wr = 1'b1; d_imm_sel = 1'b1; end
            default:  d_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.INSTR_VALID) state_nxt = S_DECODE;
`ifdef ILLEGAL_OP_TRAP_EN
            S_DECODE: state_nxt = d_illegal ? S_TRAP : S_EXEC;
            S_TRAP:   state_nxt = S_TRAP;
`else
            S_DECODE: state_nxt = S_EXEC;
`endif
            S_EXEC:   state_nxt = mem_q ? S_MEM : S_RETIRE;
            S_MEM:    if (!bus.MEM_BUSYWAIT) state_nxt = S_RETIRE;
            S_RETIRE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            instr_q <= '0;
        end else if (state == S_IDLE && bus.INSTR_VALID) begin
            instr_q <= bus.INSTRUCTION;
        end
    end

    // Controls load at the end of DECODE, hold through RETIRE and clear on the way back to IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            alu_op_q  <= '0;
            neg_q     <= 1'b0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            rr1_q     <= '0;
            rr2_q     <= '0;
            wreg_q    <= '0;
            offset_q  <= '0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            jump_q    <= 1'b0;
            beq_q     <= 1'b0;
            mem_q     <= 1'b0;
            taken_q   <= 1'b0;
        end else if (state == S_DECODE) begin
            alu_op_q  <= d_alu_op;
            neg_q     <= d_neg;
            imm_sel_q <= d_imm_sel;
            imm_q     <= instr_q[7:0];
            rr1_q     <= instr_q[8 +: REG_ADDR_W];
            rr2_q     <= instr_q[0 +: REG_ADDR_W];
            wreg_q    <= instr_q[16 +: REG_ADDR_W];
            offset_q  <= instr_q[23:16];
            we_q      <= d_we;
            rd_q      <= d_rd;
            wr_q      <= d_wr;
            jump_q    <= d_jump;
            beq_q     <= d_beq;
            mem_q     <= d_rd | d_wr;
            taken_q   <= 1'b0;
        end else if (state == S_EXEC) begin
            if (beq_q) taken_q <= bus.ZERO;
        end else if (state == S_RETIRE) begin
            alu_op_q  <= '0;
            neg_q     <= 1'b0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            rr1_q     <= '0;
            rr2_q     <= '0;
            wreg_q    <= '0;
            offset_q  <= '0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            jump_q    <= 1'b0;
            beq_q     <= 1'b0;
            mem_q     <= 1'b0;
            taken_q   <= 1'b0;
        end
    end

    always_comb begin
        bus.INSTR_READY = (state == S_IDLE) && RESET;
        bus.ALU_OP      = alu_op_q;
        bus.NEG_SEL     = neg_q;
        bus.IMM_SEL     = imm_sel_q;
        bus.IMM         = imm_q;
        bus.READREG1    = rr1_q;
        bus.READREG2    = rr2_q;
        bus.WRITEREG    = wreg_q;
        bus.OFFSET      = offset_q;
        bus.MEM_READ    = (state == S_MEM) && rd_q;
        bus.MEM_WRITE   = (state == S_MEM) && wr_q;
        bus.WRITEENABLE = (state == S_RETIRE) && we_q;
        bus.PC_BRANCH   = (state == S_RETIRE) && (jump_q || taken_q);
        bus.PC_EN       = (state == S_RETIRE) && !(jump_q || taken_q);
`ifdef ILLEGAL_OP_TRAP_EN
        bus.ILLEGAL     = (state == S_TRAP);
`endif
    end

    // Opcode bits beyond the decoded set and register-field MSBs are intentionally not used.
    logic unused_bits;
    assign unused_bits = ^{instr_q[31:24], instr_q[15:8], d_illegal};

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
// Build with ILLEGAL_OP_TRAP_EN defined to exercise the trap variant.
module tb_control_sequencer;
    logic CLK;
    logic RESET;
    int   n_tests;
    int   n_failed;
    int   mem_cycles;

    control_sequencer_if #(.REG_ADDR_W(3)) bus ();

    control_sequencer #(.OPCODE_W(8), .REG_ADDR_W(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.INSTRUCTION = instr;
        bus.INSTR_VALID = 1'b1;
        step();
        bus.INSTR_VALID = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.INSTR_READY, bus.ALU_OP, bus.NEG_SEL, bus.IMM_SEL, bus.WRITEENABLE,
                    bus.MEM_READ, bus.MEM_WRITE, bus.PC_EN, bus.PC_BRANCH}) |
               32'({bus.IMM, bus.OFFSET, bus.READREG1, bus.READREG2, bus.WRITEREG}) << 8;
    endfunction

    initial begin
        n_tests = 0;
        n_failed = 0;
        RESET = 1'b0;
        bus.INSTRUCTION = '0;
        bus.INSTR_VALID = 1'b0;
        bus.ZERO = 1'b0;
        bus.MEM_BUSYWAIT = 1'b0;
        #2;
        check("reset_outs", all_outs(), 32'h0);
        repeat (3) step();
        RESET = 1'b1;
        #1;
        check("reset_rdy", bus.INSTR_READY, 1'b1);

        // add r3,r1,r2
        issue(32'h02030102);
        check("add_dec_rdy", bus.INSTR_READY, 1'b0);
        step();
        check("add_aluop", bus.ALU_OP, 3'b001);
        check("add_rr1", bus.READREG1, 3'd1);
        check("add_rr2", bus.READREG2, 3'd2);
        check("add_exec_we", bus.WRITEENABLE, 1'b0);
        step();
        check("add_we", bus.WRITEENABLE, 1'b1);
        check("add_wreg", bus.WRITEREG, 3'd3);
        check("add_pcen", bus.PC_EN, 1'b1);
        check("add_pcbr", bus.PC_BRANCH, 1'b0);
        step();
        check("add_idle_rdy", bus.INSTR_READY, 1'b1);
        check("add_idle_clr", {bus.ALU_OP, bus.WRITEENABLE, bus.PC_EN}, 5'b0);

        // sub r4,r5,r6 then loadi r2,0x2A
        issue(32'h03040506);
        step();
        check("sub_neg", bus.NEG_SEL, 1'b1);
        check("sub_aluop", bus.ALU_OP, 3'b001);
        check("sub_imm_sel", bus.IMM_SEL, 1'b0);
        step();
        check("sub_wreg", bus.WRITEREG, 3'd4);
        step();
        issue(32'h0002002A);
        step();
        check("loadi_imm_sel", bus.IMM_SEL, 1'b1);
        check("loadi_imm", bus.IMM, 8'h2A);
        check("loadi_aluop", bus.ALU_OP, 3'b000);
        check("loadi_neg", bus.NEG_SEL, 1'b0);
        step();
        check("loadi_wreg", bus.WRITEREG, 3'd2);
        check("loadi_we", bus.WRITEENABLE, 1'b1);
        step();

        // beq taken: ZERO only high during EXEC
        issue(32'h07FE0102);
        bus.ZERO = 1'b0;
        step();
        bus.ZERO = 1'b1;
        check("beq_aluop", bus.ALU_OP, 3'b101);
        check("beq_neg", bus.NEG_SEL, 1'b1);
        step();
        bus.ZERO = 1'b0;
        check("beq_t_br", bus.PC_BRANCH, 1'b1);
        check("beq_t_pcen", bus.PC_EN, 1'b0);
        check("beq_t_off", bus.OFFSET, 8'hFE);
        check("beq_t_we", bus.WRITEENABLE, 1'b0);
        step();

        // beq not taken: ZERO high outside EXEC must not count
        issue(32'h07FE0102);
        bus.ZERO = 1'b1;
        step();
        bus.ZERO = 1'b0;
        step();
        bus.ZERO = 1'b1;
        check("beq_nt_br", bus.PC_BRANCH, 1'b0);
        check("beq_nt_pcen", bus.PC_EN, 1'b1);
        step();
        bus.ZERO = 1'b0;

        // j +5
        issue(32'h06050000);
        step();
        check("j_aluop", bus.ALU_OP, 3'b100);
        step();
        check("j_br", bus.PC_BRANCH, 1'b1);
        check("j_pcen", bus.PC_EN, 1'b0);
        check("j_off", bus.OFFSET, 8'h05);
        step();

        // lwd r1 <- [r2], busy for 4 MEM cycles, stray instruction offered during the stall
        bus.MEM_BUSYWAIT = 1'b1;
        issue(32'h08010203);
        bus.INSTRUCTION = 32'h02070303;
        bus.INSTR_VALID = 1'b1;
        step();
        check("lwd_exec_rd", bus.MEM_READ, 1'b0);
        check("lwd_aluop", bus.ALU_OP, 3'b000);
        step();
        mem_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.MEM_READ) mem_cycles++;
            check("lwd_stall_we", bus.WRITEENABLE, 1'b0);
            check("lwd_stall_rdy", bus.INSTR_READY, 1'b0);
            step();
        end
        bus.MEM_BUSYWAIT = 1'b0;
        if (bus.MEM_READ) mem_cycles++;
        step();
        check("lwd_rd_cycles", 32'(mem_cycles), 32'd5);
        check("lwd_ret_rd", bus.MEM_READ, 1'b0);
        check("lwd_we", bus.WRITEENABLE, 1'b1);
        check("lwd_wreg", bus.WRITEREG, 3'd1);
        check("lwd_rr1", bus.READREG1, 3'd2);
        check("lwd_pcen", bus.PC_EN, 1'b1);
        bus.INSTR_VALID = 1'b0;
        step();
        check("lwd_idle_rdy", bus.INSTR_READY, 1'b1);

        // swi: single MEM cycle, immediate address, no write-back
        issue(32'h0B000407);
        step();
        check("swi_imm_sel", bus.IMM_SEL, 1'b1);
        step();
        check("swi_wr", bus.MEM_WRITE, 1'b1);
        check("swi_rd", bus.MEM_READ, 1'b0);
        step();
        check("swi_ret_wr", bus.MEM_WRITE, 1'b0);
        check("swi_we", bus.WRITEENABLE, 1'b0);
        check("swi_pcen", bus.PC_EN, 1'b1);
        step();

        // illegal opcode 0xC0
        issue(32'hC0010203);
`ifdef ILLEGAL_OP_TRAP_EN
        step();
        bus.INSTRUCTION = 32'h02030102;
        bus.INSTR_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("trap_illegal", bus.ILLEGAL, 1'b1);
            check("trap_rdy", bus.INSTR_READY, 1'b0);
            check("trap_pc", {bus.PC_EN, bus.PC_BRANCH, bus.WRITEENABLE, bus.MEM_READ, bus.MEM_WRITE}, 5'b0);
            step();
        end
        bus.INSTR_VALID = 1'b0;
`else
        step();
        step();
        check("nop_we", bus.WRITEENABLE, 1'b0);
        check("nop_pcen", bus.PC_EN, 1'b1);
        check("nop_mem", {bus.MEM_READ, bus.MEM_WRITE}, 2'b00);
        step();
        check("nop_idle_rdy", bus.INSTR_READY, 1'b1);
`endif

        // reset in the middle of an outstanding memory read
        RESET = 1'b0;
        #1;
        RESET = 1'b1;
        #1;
        bus.MEM_BUSYWAIT = 1'b1;
        issue(32'h09050000);
        step();
        step();
        check("rst_mem_rd_pre", bus.MEM_READ, 1'b1);
        #2;
        RESET = 1'b0;
        #1;
        check("rst_mem_outs", all_outs(), 32'h0);
`ifdef ILLEGAL_OP_TRAP_EN
        check("rst_illegal", bus.ILLEGAL, 1'b0);
`endif
        repeat (3) step();
        check("rst_hold_outs", all_outs(), 32'h0);
        RESET = 1'b1;
        #1;
        check("rst_rel_rdy", bus.INSTR_READY, 1'b1);
        check("rst_rel_rd", bus.MEM_READ, 1'b0);
        bus.MEM_BUSYWAIT = 1'b0;
        step();
        check("rst_rel_rdy2", bus.INSTR_READY, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
